pc_sequencer: RTL and testbench

Parametrised fetch-address sequencer for the pipelined MIPS core, replacing the fixed 32-bit program counter. It adds two prioritised redirect sources (EX-stage branch, ID-stage jump), a halt/resume state machine and a single-step mode driven by the debug unit. An optional trace buffer records recent redirect targets. It sits at the head of the IF stage and drives the instruction-memory address.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_trace_buffer.sv | 49 ++++
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-address sequencer: state encoding and o_state width.
package pc_pkg;

  localparam int PC_STATE_W = 2;

  localparam logic [PC_STATE_W-1:0] PC_RUN       = 2'd0;
  localparam logic [PC_STATE_W-1:0] PC_STEP_WAIT = 2'd1;
  localparam logic [PC_STATE_W-1:0] PC_HALTED    = 2'd2;

  typedef enum logic [PC_STATE_W-1:0] {
    ST_RUN       = PC_RUN,
    ST_STEP_WAIT = PC_STEP_WAIT,
    ST_HALTED    = PC_HALTED
  } pc_state_e;

endpackage

// File: rtl/pc_trace_buffer.sv
// Circular buffer of recent redirect targets, read newest-first with one-cycle latency.
module pc_trace_buffer #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [ADDR_W-1:0]        o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  r_wr_ptr;
  logic [IDX_W:0]    r_count;
  logic [ADDR_W-1:0] r_rd_data;
  logic [IDX_W-1:0]  w_rd_ptr;
  logic              w_rd_hit;

  // Newest entry sits just behind the write pointer; the pointer width gives the wrap.
  assign w_rd_ptr = r_wr_ptr - IDX_W'(1) - i_rd_idx;
  assign w_rd_hit = ({1'b0, i_rd_idx} < r_count);

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + IDX_W'(1);
        if (r_count != (IDX_W+1)'(DEPTH)) r_count <= r_count + (IDX_W+1)'(1);
      end
      r_rd_data <= w_rd_hit ? r_mem[w_rd_ptr] : '0;
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_count   = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: branch/jump redirects, halt/resume and single-step control.
// Define PC_TRACE_EN to build the redirect-target trace buffer.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int                 INSTR_BYTES  = 4,
  parameter int                 TRACE_DEPTH  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_mode_step,
  input  logic                           i_step,
  input  logic                           i_resume,
  input  logic                           i_stall,
  input  logic                           i_halt,
  input  logic                           i_branch,
  input  logic [ADDR_W-1:0]              i_branch_address,
  input  logic                           i_jump,
  input  logic [ADDR_W-1:0]              i_jump_address,
  input  logic [$clog2(TRACE_DEPTH)-1:0] i_trace_idx,
  output logic [ADDR_W-1:0]              o_pc,
  output logic [ADDR_W-1:0]              o_pc_plus,
  output logic                           o_advance,
  output logic [PC_STATE_W-1:0]          o_state,
  output logic                           o_misaligned,
  output logic [ADDR_W-1:0]              o_trace_addr,
  output logic [$clog2(TRACE_DEPTH):0]   o_trace_count
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] INCR     = ADDR_W'(INSTR_BYTES);

  pc_state_e         r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic              r_step_pending, w_pending_next;
  logic              r_advance, r_misaligned;
  logic              w_step_go, w_adv, w_redirect;
  logic [ADDR_W-1:0] w_target, w_pc_next;

  assign w_step_go  = i_step | r_step_pending;
  assign w_adv      = !i_stall && !i_halt && (r_state != ST_HALTED) &&
                      ((r_state == ST_RUN) || w_step_go);
  assign w_redirect = i_branch | i_jump;
  assign w_target   = i_branch ? i_branch_address : i_jump_address;
  assign w_pc_next  = w_redirect ? (w_target & ~LOW_MASK) : (r_pc + INCR);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:       if (i_mode_step)  w_state_next = ST_STEP_WAIT;
      ST_STEP_WAIT: if (!i_mode_step) w_state_next = ST_RUN;
      ST_HALTED:    if (i_resume)     w_state_next = i_mode_step ? ST_STEP_WAIT : ST_RUN;
      default:                        w_state_next = ST_RUN;
    endcase
    if (i_halt && (r_state != ST_HALTED)) w_state_next = ST_HALTED;
  end

  // A step that lands on a stall is remembered until it can be honoured; halting forgets it.
  always_comb begin
    w_pending_next = r_step_pending;
    if (w_adv)
      w_pending_next = 1'b0;
    else if (w_state_next == ST_HALTED)
      w_pending_next = 1'b0;
    else if (i_step && i_stall)
      w_pending_next = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_RUN;
      r_pc           <= RESET_VECTOR;
      r_step_pending <= 1'b0;
      r_advance      <= 1'b0;
      r_misaligned   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_step_pending <= w_pending_next;
      r_advance      <= w_adv;
      r_misaligned   <= w_adv && w_redirect && (|(w_target & LOW_MASK));
      if (w_adv) r_pc <= w_pc_next;
    end
  end

  assign o_pc         = r_pc;
  assign o_pc_plus    = r_pc + INCR;
  assign o_advance    = r_advance;
  assign o_state      = r_state;
  assign o_misaligned = r_misaligned;

`ifdef PC_TRACE_EN
  pc_trace_buffer #(
    .ADDR_W (ADDR_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (w_adv & w_redirect),
    .i_wr_data (w_pc_next),
    .i_rd_idx  (i_trace_idx),
    .o_rd_data (o_trace_addr),
    .o_count   (o_trace_count)
  );
`else
  logic w_unused_trace_idx;
  assign w_unused_trace_idx = ^i_trace_idx;
  assign o_trace_addr       = '0;
  assign o_trace_count      = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run against a cycle model.
module tb_pc_sequencer;

  localparam int AW = 32;
  localparam int TD = 8;
  localparam int IW = 3;
`ifdef PC_TRACE_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_reset, i_mode_step, i_step, i_resume, i_stall, i_halt;
  logic          i_branch, i_jump;
  logic [AW-1:0] i_branch_address, i_jump_address;
  logic [IW-1:0] i_trace_idx;
  logic [AW-1:0] o_pc, o_pc_plus, o_trace_addr;
  logic          o_advance, o_misaligned;
  logic [1:0]    o_state;
  logic [IW:0]   o_trace_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: PC, state as 0/1/2, pending step, trace as a newest-first queue.
  logic [AW-1:0] m_pc;
  int            m_state;
  bit            m_pend, m_adv, m_mis;
  logic [AW-1:0] m_tq[$];
  logic [AW-1:0] m_trace_addr;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_mode_step      (i_mode_step),
    .i_step           (i_step),
    .i_resume         (i_resume),
    .i_stall          (i_stall),
    .i_halt           (i_halt),
    .i_branch         (i_branch),
    .i_branch_address (i_branch_address),
    .i_jump           (i_jump),
    .i_jump_address   (i_jump_address),
    .i_trace_idx      (i_trace_idx),
    .o_pc             (o_pc),
    .o_pc_plus        (o_pc_plus),
    .o_advance        (o_advance),
    .o_state          (o_state),
    .o_misaligned     (o_misaligned),
    .o_trace_addr     (o_trace_addr),
    .o_trace_count    (o_trace_count)
  );

  task automatic clear_pulses();
    i_step = 0; i_resume = 0; i_halt = 0; i_branch = 0; i_jump = 0; i_stall = 0;
  endtask

  // Advances the model by the rules for the current inputs, then clocks the DUT.
  task automatic tick();
    bit            adv;
    logic [AW-1:0] tgt, rd;
    rd = (TRACE_ON && (int'(i_trace_idx) < m_tq.size())) ? m_tq[i_trace_idx] : '0;
    if (i_reset) begin
      m_pc = '0; m_state = 0; m_pend = 0; m_adv = 0; m_mis = 0;
      m_tq.delete(); m_trace_addr = '0;
    end else begin
      adv = !i_stall && !i_halt && m_state != 2 && (m_state == 0 || i_step || m_pend);
      tgt = i_branch ? i_branch_address : i_jump_address;
      m_mis = adv && (i_branch || i_jump) && (tgt[1:0] != 2'b00);
      if (adv) m_pend = 0;
      else if (i_halt && m_state != 2) m_pend = 0;
      else if (i_step && i_stall && m_state != 2) m_pend = 1;
      if (i_halt && m_state != 2) m_state = 2;
      else if (m_state == 0 && i_mode_step) m_state = 1;
      else if (m_state == 1 && !i_mode_step) m_state = 0;
      else if (m_state == 2 && i_resume) m_state = i_mode_step ? 1 : 0;
      if (adv) begin
        if (i_branch || i_jump) begin
          m_pc = {tgt[AW-1:2], 2'b00};
          if (TRACE_ON) begin
            m_tq.push_front(m_pc);
            if (m_tq.size() > TD) void'(m_tq.pop_back());
          end
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
      m_adv = adv;
      m_trace_addr = rd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1; i_mode_step = 0; clear_pulses();
    i_branch_address = '0; i_jump_address = '0; i_trace_idx = '0;
    tick(); tick();
    i_reset = 0;
    n_cmp++; if (o_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", o_pc, 32'h0); end
    n_cmp++; if (o_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
    n_cmp++; if (o_advance !== 1'b0) begin n_bad++; $display("FAIL reset_advance: got %b want 0", o_advance); end
    n_cmp++; if (o_misaligned !== 1'b0) begin n_bad++; $display("FAIL reset_misaligned: got %b want 0", o_misaligned); end
    n_cmp++; if (o_trace_count !== '0) begin n_bad++; $display("FAIL reset_trace_count: got %0d want 0", o_trace_count); end
    n_cmp++; if (o_trace_addr !== '0) begin n_bad++; $display("FAIL reset_trace_addr: got %h want 0", o_trace_addr); end
    $display("reset: pc=%h state=%0d", o_pc, o_state);
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (o_pc !== 32'(4 * k)) begin n_bad++; $display("FAIL seq_pc%0d: got %h want %h", k, o_pc, 32'(4 * k)); end
      n_cmp++; if (o_advance !== 1'b1) begin n_bad++; $display("FAIL seq_advance%0d: got %b want 1", k, o_advance); end
      n_cmp++; if (o_pc_plus !== 32'(4 * k + 4)) begin n_bad++; $display("FAIL seq_pc_plus%0d: got %h want %h", k, o_pc_plus, 32'(4 * k + 4)); end
      $display("seq: pc=%h", o_pc);
    end
  endtask

  task automatic test_priority();
    i_branch = 1; i_branch_address = 32'h100; i_jump = 1; i_jump_address = 32'h200;
    tick(); clear_pulses();
    n_cmp++; if (o_pc !== 32'h100) begin n_bad++; $display("FAIL prio_branch_wins: got %h want 100", o_pc); end
    n_cmp++; if (o_misaligned !== 1'b0) begin n_bad++; $display("FAIL prio_aligned: got %b want 0", o_misaligned); end
    i_jump = 1; i_jump_address = 32'h203;
    tick(); clear_pulses();
    n_cmp++; if (o_pc !== 32'h200) begin n_bad++; $display("FAIL jump_aligned_pc: got %h want 200", o_pc); end
    n_cmp++; if (o_misaligned !== 1'b1) begin n_bad++; $display("FAIL jump_misaligned: got %b want 1", o_misaligned); end
    tick();
    n_cmp++; if (o_misaligned !== 1'b0) begin n_bad++; $display("FAIL misaligned_one_cycle: got %b want 0", o_misaligned); end
    n_cmp++; if (o_pc !== 32'h204) begin n_bad++; $display("FAIL after_jump_pc: got %h want 204", o_pc); end
    $display("priority: pc=%h", o_pc);
  endtask

  task automatic test_step();
    i_mode_step = 1;
    tick();
    n_cmp++; if (o_state !== 2'd1) begin n_bad++; $display("FAIL step_state: got %0d want 1", o_state); end
    n_cmp++; if (o_pc !== 32'h208) begin n_bad++; $display("FAIL step_entry_pc: got %h want 208", o_pc); end
    tick(); tick();
    n_cmp++; if (o_pc !== 32'h208 || o_advance !== 1'b0) begin n_bad++; $display("FAIL step_idle: got pc=%h adv=%b want 208/0", o_pc, o_advance); end
    i_stall = 1; i_step = 1;
    tick(); i_step = 0;
    n_cmp++; if (o_pc !== 32'h208) begin n_bad++; $display("FAIL step_stall1: got %h want 208", o_pc); end
    i_step = 1;
    tick(); i_step = 0;
    tick();
    n_cmp++; if (o_pc !== 32'h208) begin n_bad++; $display("FAIL step_stall3: got %h want 208", o_pc); end
    i_stall = 0;
    tick();
    n_cmp++; if (o_pc !== 32'h20C || o_advance !== 1'b1) begin n_bad++; $display("FAIL step_release: got pc=%h adv=%b want 20c/1", o_pc, o_advance); end
    tick(); tick();
    n_cmp++; if (o_pc !== 32'h20C) begin n_bad++; $display("FAIL step_no_extra: got %h want 20c", o_pc); end
    i_step = 1; tick(); i_step = 0;
    n_cmp++; if (o_pc !== 32'h210) begin n_bad++; $display("FAIL step_plain: got %h want 210", o_pc); end
    i_mode_step = 0; tick();
    n_cmp++; if (o_state !== 2'd0 || o_pc !== 32'h210) begin n_bad++; $display("FAIL step_exit: got st=%0d pc=%h want 0/210", o_state, o_pc); end
    $display("step: pc=%h state=%0d", o_pc, o_state);
  endtask

  task automatic test_halt();
    i_branch = 1; i_branch_address = 32'h20; tick(); clear_pulses();
    i_halt = 1; tick(); i_halt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if (o_pc !== 32'h20 || o_state !== 2'd2) begin n_bad++; $display("FAIL halt_hold%0d: got pc=%h st=%0d want 20/2", c, o_pc, o_state); end
    end
    i_resume = 1; tick(); i_resume = 0;
    n_cmp++; if (o_state !== 2'd0 || o_pc !== 32'h20) begin n_bad++; $display("FAIL resume_cycle: got st=%0d pc=%h want 0/20", o_state, o_pc); end
    tick();
    n_cmp++; if (o_pc !== 32'h24) begin n_bad++; $display("FAIL resume_advance: got %h want 24", o_pc); end
    i_mode_step = 1; tick();
    i_halt = 1; i_step = 1; tick(); clear_pulses();
    n_cmp++; if (o_state !== 2'd2 || o_pc !== 32'h28) begin n_bad++; $display("FAIL halt_beats_step: got st=%0d pc=%h want 2/28", o_state, o_pc); end
    i_resume = 1; tick(); i_resume = 0; tick();
    n_cmp++; if (o_state !== 2'd1 || o_pc !== 32'h28) begin n_bad++; $display("FAIL step_discarded: got st=%0d pc=%h want 1/28", o_state, o_pc); end
    i_mode_step = 0; tick(); tick();
    n_cmp++; if (o_pc !== 32'h2C) begin n_bad++; $display("FAIL halt_back_to_run: got %h want 2c", o_pc); end
    $display("halt: pc=%h state=%0d", o_pc, o_state);
  endtask

  task automatic test_wrap_and_reset_halted();
    i_branch = 1; i_branch_address = 32'hFFFF_FFFE; tick(); clear_pulses();
    n_cmp++; if (o_pc !== 32'hFFFF_FFFC || o_misaligned !== 1'b1) begin n_bad++; $display("FAIL wrap_top: got pc=%h mis=%b want fffffffc/1", o_pc, o_misaligned); end
    tick();
    n_cmp++; if (o_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_zero: got %h want 0", o_pc); end
    tick(); i_halt = 1; tick(); i_halt = 0; tick();
    i_reset = 1; tick(); i_reset = 0;
    n_cmp++; if (o_pc !== 32'h0 || o_state !== 2'd0) begin n_bad++; $display("FAIL reset_halted: got pc=%h st=%0d want 0/0", o_pc, o_state); end
    $display("wrap/reset: pc=%h state=%0d", o_pc, o_state);
  endtask

  task automatic test_trace();
    logic [AW-1:0] want;
    for (int k = 1; k <= 2; k++) begin
      i_jump = 1; i_jump_address = 32'(16 * k); tick();
    end
    clear_pulses();
    i_trace_idx = 3'd1; tick();
    want = TRACE_ON ? 32'h10 : 32'h0;
    n_cmp++; if (o_trace_addr !== want) begin n_bad++; $display("FAIL trace_idx1_early: got %h want %h", o_trace_addr, want); end
    i_trace_idx = 3'd5; tick();
    n_cmp++; if (o_trace_addr !== 32'h0) begin n_bad++; $display("FAIL trace_beyond_count: got %h want 0", o_trace_addr); end
    for (int k = 3; k <= 10; k++) begin
      i_jump = 1; i_jump_address = 32'(16 * k); tick();
    end
    clear_pulses();
    i_trace_idx = 3'd0; tick();
    n_cmp++; if (o_trace_count !== (TRACE_ON ? 4'd8 : 4'd0)) begin n_bad++; $display("FAIL trace_count: got %0d want %0d", o_trace_count, TRACE_ON ? 8 : 0); end
    want = TRACE_ON ? 32'hA0 : 32'h0;
    n_cmp++; if (o_trace_addr !== want) begin n_bad++; $display("FAIL trace_idx0: got %h want %h", o_trace_addr, want); end
    i_trace_idx = 3'd7; tick();
    want = TRACE_ON ? 32'h30 : 32'h0;
    n_cmp++; if (o_trace_addr !== want) begin n_bad++; $display("FAIL trace_idx7: got %h want %h", o_trace_addr, want); end
    $display("trace: count=%0d last=%h", o_trace_count, o_trace_addr);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      i_reset     = ($urandom_range(99) == 0);
      if ($urandom_range(19) == 0) i_mode_step = ~i_mode_step;
      i_step      = ($urandom_range(3) == 0);
      i_resume    = ($urandom_range(5) == 0);
      i_stall     = ($urandom_range(3) == 0);
      i_halt      = ($urandom_range(24) == 0);
      i_branch    = ($urandom_range(5) == 0);
      i_jump      = ($urandom_range(5) == 0);
      i_branch_address = $urandom;
      i_jump_address   = $urandom;
      i_trace_idx = 3'($urandom_range(7));
      tick();
      n_cmp++;
      if (o_pc !== m_pc || o_state !== 2'(m_state) || o_advance !== m_adv ||
          o_misaligned !== m_mis || o_pc_plus !== m_pc + 32'd4 ||
          o_trace_count !== 4'(TRACE_ON ? m_tq.size() : 0) || o_trace_addr !== m_trace_addr) begin
        n_bad++;
        $display("FAIL rand_cycle%0d: got pc=%h st=%0d adv=%b mis=%b cnt=%0d tr=%h want pc=%h st=%0d adv=%b mis=%b cnt=%0d tr=%h",
                 c, o_pc, o_state, o_advance, o_misaligned, o_trace_count, o_trace_addr,
                 m_pc, m_state, m_adv, m_mis, TRACE_ON ? m_tq.size() : 0, m_trace_addr);
      end else begin
        $display("rand %0d: pc=%h st=%0d adv=%b", c, o_pc, o_state, o_advance);
      end
    end
    i_reset = 0; i_mode_step = 0; clear_pulses();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_priority();
    test_step();
    test_halt();
    test_wrap_and_reset_halted();
    test_trace();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
